// File: rtl/remote_comm.sv
// Host-side UART endpoint: sends a 16-bit command as two 8N1 bytes (high byte first) and
// receives response bytes. Define RESP_TIMEOUT_EN to add the response-timeout counter.
module remote_comm #(
  parameter int unsigned BAUD_DIV    = 434,
  parameter int unsigned TIMEOUT_CYC = 2**24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        busy,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic        resp_timeout
);

  if (BAUD_DIV < 4 || BAUD_DIV > 4095 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 2**25)
  begin : g_bad_param
    $error("remote_comm: BAUD_DIV or TIMEOUT_CYC out of range");
  end

  localparam logic [11:0] BaudLoad = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BaudHalf = 12'(BAUD_DIV / 2);

  typedef enum logic [1:0] {TxIdle, TxHi, TxLo, TxDone} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

  // ---------------------------------------------------------------- transmit
  tx_state_e   tx_state_q;
  logic [11:0] tx_baud_q;
  logic [3:0]  tx_bit_q;
  logic [9:0]  tx_shift_q;
  logic [7:0]  tx_lo_q;
  logic        busy_q;
  logic        cmd_snt_q;
  logic        tx_accept;

  // DONE accepts a new command too, so back-to-back commands have no idle gap.
  assign tx_accept = snd_cmd && (tx_state_q == TxIdle || tx_state_q == TxDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_lo_q    <= '0;
      busy_q     <= 1'b0;
      cmd_snt_q  <= 1'b0;
    end else begin
      cmd_snt_q <= 1'b0;
      case (tx_state_q)
        TxIdle, TxDone: begin
          tx_state_q <= TxIdle;
          if (tx_accept) begin
            tx_shift_q <= {1'b1, cmd[15:8], 1'b0};
            tx_lo_q    <= cmd[7:0];
            tx_baud_q  <= BaudLoad;
            tx_bit_q   <= '0;
            busy_q     <= 1'b1;
            tx_state_q <= TxHi;
          end
        end
        TxHi, TxLo: begin
          if (tx_baud_q != 12'd0) begin
            tx_baud_q <= tx_baud_q - 12'd1;
          end else begin
            tx_baud_q <= BaudLoad;
            if (tx_bit_q == 4'd9) begin
              tx_bit_q <= '0;
              if (tx_state_q == TxHi) begin
                tx_shift_q <= {1'b1, tx_lo_q, 1'b0};
                tx_state_q <= TxLo;
              end else begin
                tx_shift_q <= '1;
                busy_q     <= 1'b0;
                cmd_snt_q  <= 1'b1;
                tx_state_q <= TxDone;
              end
            end else begin
              tx_shift_q <= {1'b1, tx_shift_q[9:1]};
              tx_bit_q   <= tx_bit_q + 4'd1;
            end
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign TX      = tx_shift_q[0];
  assign busy    = busy_q;
  assign cmd_snt = cmd_snt_q;

  // ----------------------------------------------------------------- receive
  rx_state_e   rx_state_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [11:0] rx_baud_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_data_q;
  logic [7:0]  resp_q;
  logic        resp_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      // A completing byte below overrides this clear.
      if (clr_resp_rdy || tx_accept) resp_rdy_q <= 1'b0;
      case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_baud_q  <= BaudHalf;
            rx_state_q <= RxStart;
          end
        end
        RxStart: begin
          if (rx_baud_q != 12'd0) begin
            rx_baud_q <= rx_baud_q - 12'd1;
          end else if (rx_sync_q) begin
            rx_state_q <= RxIdle;
          end else begin
            rx_baud_q  <= BaudLoad;
            rx_bit_q   <= '0;
            rx_state_q <= RxData;
          end
        end
        RxData: begin
          if (rx_baud_q != 12'd0) begin
            rx_baud_q <= rx_baud_q - 12'd1;
          end else begin
            rx_data_q <= {rx_sync_q, rx_data_q[7:1]};
            rx_baud_q <= BaudLoad;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end
        end
        RxStop: begin
          if (rx_baud_q != 12'd0) begin
            rx_baud_q <= rx_baud_q - 12'd1;
          end else if (rx_sync_q) begin
            resp_q     <= rx_data_q;
            resp_rdy_q <= 1'b1;
            rx_state_q <= RxIdle;
          end else begin
            rx_state_q <= RxWait;
          end
        end
        RxWait: begin
          if (rx_sync_q) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

  // ----------------------------------------------------------------- timeout
`ifdef RESP_TIMEOUT_EN
  localparam logic [24:0] TmoLast = 25'(TIMEOUT_CYC - 1);

  logic [24:0] tmo_cnt_q;
  logic        tmo_run_q;
  logic        tmo_pulse_q;
  logic        rdy_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      tmo_run_q   <= 1'b0;
      tmo_pulse_q <= 1'b0;
      rdy_prev_q  <= 1'b0;
    end else begin
      rdy_prev_q  <= resp_rdy_q;
      tmo_pulse_q <= 1'b0;
      if (tx_accept || (resp_rdy_q && !rdy_prev_q)) begin
        tmo_run_q <= 1'b0;
      end else if (cmd_snt_q) begin
        tmo_run_q <= 1'b1;
        tmo_cnt_q <= 25'd1;
      end else if (tmo_run_q) begin
        if (tmo_cnt_q == TmoLast) begin
          tmo_pulse_q <= 1'b1;
          tmo_run_q   <= 1'b0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 25'd1;
        end
      end
    end
  end

  assign resp_timeout = tmo_pulse_q;
`else
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm at BAUD_DIV=16, TIMEOUT_CYC=1000.
module tb_remote_comm;

  localparam int unsigned B = 16;
  localparam int unsigned TMO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        busy;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;
  logic        resp_timeout;

  remote_comm #(.BAUD_DIV(B), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .snd_cmd      (snd_cmd),
    .cmd_snt      (cmd_snt),
    .busy         (busy),
    .TX           (TX),
    .RX           (RX),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy),
    .resp_timeout (resp_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tmo_total = 0;

  // Reference state of the receive side: last good byte and unread flag.
  logic [7:0] m_resp = 8'h00;
  logic       m_rdy  = 1'b0;

  always @(negedge clk) if (resp_timeout === 1'b1) tmo_total++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 8N1 frame bit idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic send_check(input logic [15:0] c, input logic [7:0] hi, input logic [7:0] lo,
                            input bit inject, input bit chain, input logic [15:0] chain_cmd);
    int tx_bad = 0;
    int busy_bad = 0;
    int at = -1;
    cmd = c;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    m_rdy = 1'b0;
    for (int j = 1; j <= 321; j++) begin
      if (j > 1) tick();
      if (inject && j == 50) begin cmd = 16'hFFFF; snd_cmd = 1'b1; end
      if (inject && j == 51) snd_cmd = 1'b0;
      if (j <= 320) begin
        int idx = (j - 1) / B;
        logic [7:0] byt = (idx < 10) ? hi : lo;
        if (TX !== frame_bit(byt, idx % 10)) tx_bad++;
        if (busy !== 1'b1 || cmd_snt !== 1'b0) busy_bad++;
      end else begin
        check("tx_bits", tx_bad, 0);
        check("busy_window", busy_bad, 0);
        check("cmd_snt_at_321", cmd_snt, 1);
        check("busy_drop", busy, 0);
        if (chain) begin cmd = chain_cmd; snd_cmd = 1'b1; end
      end
    end
    tick();
    snd_cmd = 1'b0;
    check("cmd_snt_one_cycle", cmd_snt, 0);
    if (chain) begin
      m_rdy = 1'b0;
      check("chain_busy", busy, 1);
      check("chain_start_bit", TX, 0);
      for (int k = 2; k <= 321; k++) begin
        tick();
        if (cmd_snt === 1'b1 && at < 0) at = k;
      end
      check("chain_cmd_snt_at", at, 321);
      tick();
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit stop);
    for (int i = 0; i < 10 * B; i++) begin
      int k = i / B;
      if (k == 0)      RX = 1'b0;
      else if (k == 9) RX = stop;
      else             RX = d[k-1];
      tick();
      if (i == 9 * B + 2) check("rx_rdy_early", resp_rdy, m_rdy);
    end
    RX = 1'b1;
    if (stop) begin m_resp = d; m_rdy = 1'b1; end
    repeat (4) tick();
  endtask

  task automatic clr_rdy();
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    m_rdy = 1'b0;
    check("clr_rdy", resp_rdy, 0);
    check("clr_resp_kept", resp, m_resp);
  endtask

  task automatic check_rx(input string name);
    check({name, "_rdy"}, resp_rdy, m_rdy);
    check({name, "_resp"}, resp, m_resp);
  endtask

  typedef struct {
    logic [15:0] cmd;
    bit          inject;
    logic [7:0]  rx_byte;
    bit          rx_stop;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    logic        exp_rdy;
    logic [7:0]  exp_resp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad;
    int t0;
    vecs[0] = '{16'h2D35, 1'b1, 8'hA5, 1'b1, 8'h2D, 8'h35, 1'b1, 8'hA5};
    vecs[1] = '{16'h0000, 1'b0, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0, 8'hA5};
    vecs[2] = '{16'hFFFF, 1'b0, 8'h5A, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h5A};
    vecs[3] = '{16'h8001, 1'b0, 8'h3C, 1'b1, 8'h80, 8'h01, 1'b1, 8'h3C};

    rst = 1'b1; cmd = '0; snd_cmd = 1'b0; clr_resp_rdy = 1'b0; RX = 1'b1;
    tick(); tick();
    check("rst_tx", TX, 1);
    check("rst_busy", busy, 0);
    check("rst_cmd_snt", cmd_snt, 0);
    check("rst_resp", resp, 0);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_timeout", resp_timeout, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Mid-frame reset after a byte is held.
    rx_frame(8'hA5, 1'b1);
    check_rx("pre_rst");
    cmd = 16'h2D35; snd_cmd = 1'b1; tick(); snd_cmd = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", TX, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rdy", resp_rdy, 0);
    check("midrst_resp", resp, 0);
    tick();
    rst = 1'b0;
    m_rdy = 1'b0; m_resp = 8'h00;
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (TX !== 1'b1 || cmd_snt !== 1'b0) bad++;
    end
    check("midrst_quiet", bad, 0);

    // Table-driven send + receive.
    foreach (vecs[v]) begin
      clr_rdy();
      send_check(vecs[v].cmd, vecs[v].exp_hi, vecs[v].exp_lo, vecs[v].inject, 1'b0, 16'h0);
      rx_frame(vecs[v].rx_byte, vecs[v].rx_stop);
      check("vec_rdy", resp_rdy, vecs[v].exp_rdy);
      check("vec_resp", resp, vecs[v].exp_resp);
    end

    // Overwrite while unread keeps resp_rdy high.
    rx_frame(8'hC7, 1'b1);
    check_rx("overwrite");

    // Short low glitch is a false start; then a valid byte.
    clr_rdy();
    RX = 1'b0; repeat (4) tick();
    RX = 1'b1; repeat (40) tick();
    check_rx("glitch");
    rx_frame(8'h5A, 1'b1);
    check_rx("after_glitch");

    // Back-to-back command accepted on the cmd_snt cycle.
    send_check(16'hC3A1, 8'hC3, 8'hA1, 1'b0, 1'b1, 16'h0F0F);

    // Randomized full-duplex traffic.
    for (int r = 0; r < 6; r++) begin
      logic [15:0] c = 16'($urandom);
      logic [7:0]  d = 8'($urandom);
      bit          s = ($urandom_range(0, 3) != 0);
      fork
        send_check(c, c[15:8], c[7:0], 1'b0, 1'b0, 16'h0);
        rx_frame(d, s);
      join
      check_rx("rand");
    end

    // Response timeout: exactly one pulse TMO cycles after cmd_snt, none if answered.
    t0 = tmo_total;
    send_check(16'h1234, 8'h12, 8'h34, 1'b0, 1'b0, 16'h0);
    begin
      int first = -1;
      for (int k = 2; k <= 1100; k++) begin
        tick();
        if (resp_timeout === 1'b1 && first < 0) first = k;
      end
`ifdef RESP_TIMEOUT_EN
      check("tmo_at", first, TMO);
      check("tmo_pulses", tmo_total - t0, 1);
`else
      check("tmo_tied_low", tmo_total - t0, 0);
`endif
    end
    t0 = tmo_total;
    send_check(16'h4321, 8'h43, 8'h21, 1'b0, 1'b0, 16'h0);
    repeat (340) tick();
    rx_frame(8'hA5, 1'b1);
    repeat (600) tick();
    check("tmo_answered", tmo_total - t0, 0);
    check_rx("tmo_resp");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
